// File: rtl/muldiv_unit_pkg.sv
// Shared FUNCT codes, FSM encoding and iteration count for the multiply/divide unit.
// Also holds the operand magnitude helper used on accept.
package muldiv_unit_pkg;

   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

   localparam int MULDIV_ITER = 32;
   localparam int CNT_W       = $clog2(MULDIV_ITER);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } muldiv_state_t;

   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_unit_div_restore_step.sv
// One restoring-division step on a {remainder, quotient} pair; purely combinational.
module div_restore_step (
   input  logic [63:0] pair_i,
   input  logic [31:0] divisor_i,
   output logic [63:0] pair_o
);

   logic [32:0] shifted;
   logic [32:0] diff;

   // Remainder stays below the divisor (or its top bit is still clear when dividing by zero),
   // so bit 32 of the 33-bit difference is a reliable borrow.
   assign shifted = {pair_i[63:32], pair_i[31]};
   assign diff    = shifted - {1'b0, divisor_i};
   assign pair_o  = diff[32] ? {shifted[31:0], pair_i[30:0], 1'b0}
                             : {diff[31:0],    pair_i[30:0], 1'b1};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO, owning HI/LO; 34-cycle stall per iterative op.
// MULDIV_FAST_MUL_EN selects a single-cycle multiplier (done in C1, no stall for multiplies).
module muldiv_unit
   import muldiv_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [5:0]  funct,
   input  logic [31:0] operand_1,
   input  logic [31:0] operand_2,
   input  logic        flush,
   output logic        stall_req,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_ITER - 1);

   muldiv_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]      acc_q, acc_d;
   logic [31:0]      b_q, b_d;
   logic [31:0]      op1_q, op1_d;
   logic             neg_q, neg_d;
   logic             rneg_q, rneg_d;
   logic             dz_q, dz_d;
   logic             is_div_q, is_div_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic             done_q, done_d;

   logic        idle, accept, is_mul_f, is_div_f, is_sgn, sgn_diff, iter_f;
   logic [31:0] mag1, mag2;
   logic [63:0] div_pair, mul_pair, prod_fix;
   logic [31:0] q_fix, r_fix;

   assign idle     = (state_q == ST_IDLE);
   assign accept   = start & ~flush & idle;
   assign is_mul_f = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
   assign is_div_f = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
   assign is_sgn   = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
   assign sgn_diff = is_sgn & (operand_1[31] ^ operand_2[31]);
   assign mag1     = mag32(operand_1, is_sgn);
   assign mag2     = mag32(operand_2, is_sgn);

   div_restore_step u_step (
      .pair_i    (acc_q),
      .divisor_i (b_q),
      .pair_o    (div_pair)
   );

`ifdef MULDIV_FAST_MUL_EN
   logic [63:0] fast_prod, fast_res;
   assign fast_prod = {32'b0, mag1} * {32'b0, mag2};
   assign fast_res  = sgn_diff ? -fast_prod : fast_prod;
   assign iter_f    = is_div_f;
   assign mul_pair  = acc_q;
`else
   logic [32:0] mul_sum;
   // Add multiplicand into the upper half when the current multiplier bit is set, then shift.
   assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
   assign mul_pair = {mul_sum, acc_q[31:1]};
   assign iter_f   = is_mul_f | is_div_f;
`endif

   assign prod_fix = neg_q  ? -acc_q          : acc_q;
   assign q_fix    = neg_q  ? -acc_q[31:0]    : acc_q[31:0];
   assign r_fix    = rneg_q ? -acc_q[63:32]   : acc_q[63:32];

   assign stall_req = (start & iter_f & idle & ~flush) | ~idle;
   assign done      = done_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      b_d      = b_q;
      op1_d    = op1_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      is_div_d = is_div_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      if (flush && !idle) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (funct == FUNCT_MTHI) begin
                     hi_d = operand_1;
                  end else if (funct == FUNCT_MTLO) begin
                     lo_d = operand_1;
                  end else if (is_div_f) begin
                     state_d  = ST_DIV;
                     cnt_d    = '0;
                     acc_d    = {32'b0, mag1};
                     b_d      = mag2;
                     op1_d    = operand_1;
                     neg_d    = sgn_diff;
                     rneg_d   = is_sgn & operand_1[31];
                     dz_d     = (operand_2 == 32'd0);
                     is_div_d = 1'b1;
                  end else if (is_mul_f) begin
`ifdef MULDIV_FAST_MUL_EN
                     {hi_d, lo_d} = fast_res;
                     done_d       = 1'b1;
`else
                     state_d  = ST_MUL;
                     cnt_d    = '0;
                     acc_d    = {32'b0, mag2};
                     b_d      = mag1;
                     neg_d    = sgn_diff;
                     rneg_d   = 1'b0;
                     dz_d     = 1'b0;
                     is_div_d = 1'b0;
`endif
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               acc_d = (state_q == ST_DIV) ? div_pair : mul_pair;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_FIX;
               end
            end
            ST_FIX: begin
               if (!is_div_q) begin
                  {hi_d, lo_d} = prod_fix;
               end else if (dz_q) begin
                  hi_d = op1_q;
                  lo_d = 32'hFFFF_FFFF;
               end else begin
                  hi_d = r_fix;
                  lo_d = q_fix;
               end
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         op1_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         is_div_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         op1_q    <= op1_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         is_div_q <= is_div_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner sequences, random ops vs a plain-arithmetic model.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   localparam logic [5:0] F_MTHI = 6'h11, F_MTLO = 6'h13, F_MULT = 6'h18,
                          F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

   logic        clk, rst_n, start, flush;
   logic [5:0]  funct;
   logic [31:0] operand_1, operand_2;
   logic        stall_req, done;
   logic [31:0] hi, lo;

   int total = 0;
   int bad   = 0;

   muldiv_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .funct     (funct),
      .operand_1 (operand_1),
      .operand_2 (operand_2),
      .flush     (flush),
      .stall_req (stall_req),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [5:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ehi;
      logic [31:0] elo;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eh, output logic [31:0] el);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 0;
      r = 0;
      p = '0;
      case (f)
         F_MULT:  p = 64'(sa * sb);
         F_MULTU: p = {32'b0, a} * {32'b0, b};
         F_DIV: begin
            if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
         F_DIVU: begin
            if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
            else p = {a % b, a / b};
         end
         default: p = '0;
      endcase
      {eh, el} = p;
   endfunction

   function automatic bit is_mul(input logic [5:0] f);
      return (f == F_MULT) || (f == F_MULTU);
   endfunction

   // Called mid-cycle; start is held for one cycle (C0) and results are sampled in the done cycle.
   task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rhi, output logic [31:0] rlo,
                         output int lat, output int nst);
      bit seen;
      start = 1'b1;
      funct = f;
      operand_1 = a;
      operand_2 = b;
      nst = 0;
      lat = -1;
      rhi = '0;
      rlo = '0;
      seen = 1'b0;
      #1;
      if (stall_req) nst++;
      for (int k = 1; k <= 100 && !seen; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         #1;
         if (stall_req) nst++;
         if (done) begin
            seen = 1'b1;
            lat = k;
            rhi = hi;
            rlo = lo;
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL done_timeout actual=no_done required=done");
      end
   endtask

   vec_t vecs[$];

   initial begin
      logic [31:0] rh, rl, eh, el;
      logic [5:0]  f;
      int lat, nst, ndone;

      vecs.push_back('{"multu_ff_x2",  F_MULTU, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE});
      vecs.push_back('{"mult_m1_x2",   F_MULT,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE});
      vecs.push_back('{"mult_min_sq",  F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
      vecs.push_back('{"div_m7_2",     F_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD});
      vecs.push_back('{"divu_100_7",   F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14});
      vecs.push_back('{"div_ovf",      F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
      vecs.push_back('{"divu_5_0",     F_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF});
      vecs.push_back('{"div_m7_0",     F_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF});

      rst_n = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      funct = '0;
      operand_1 = '0;
      operand_2 = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_done", done, 0);
      chk("rst_stall", stall_req, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // MTHI then MTLO back to back: visible next cycle, never stall or done
      @(negedge clk);
      start = 1'b1; funct = F_MTHI; operand_1 = 32'h12345678;
      #1 chk("mthi_stall", stall_req, 0);
      @(negedge clk);
      funct = F_MTLO; operand_1 = 32'h9ABCDEF0;
      #1;
      chk("mthi_hi", hi, 32'h12345678);
      chk("mthi_done", done, 0);
      chk("mtlo_stall", stall_req, 0);
      @(negedge clk);
      funct = 6'h20; operand_1 = 32'hDEADBEEF;
      #1;
      chk("mtlo_lo", lo, 32'h9ABCDEF0);
      chk("mtlo_done", done, 0);
      chk("bad_funct_stall", stall_req, 0);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("bad_funct_hi", hi, 32'h12345678);
      chk("bad_funct_lo", lo, 32'h9ABCDEF0);

      // flush together with start: nothing accepted
      @(negedge clk);
      start = 1'b1; funct = F_DIVU; operand_1 = 32'd100; operand_2 = 32'd7; flush = 1'b1;
      #1 chk("flush_start_stall", stall_req, 0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1 chk("flush_start_idle", stall_req, 0);

      // DIVU flushed in C10: idle in C11, no done, HI/LO untouched
      @(negedge clk);
      start = 1'b1; funct = F_DIVU; operand_1 = 32'd100; operand_2 = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      #1 chk("flush_c10_stall", stall_req, 1);
      @(negedge clk);
      flush = 1'b0;
      #1 chk("flush_c11_stall", stall_req, 0);
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         #1 if (done) ndone++;
      end
      chk("flush_no_done", ndone, 0);
      chk("flush_hi", hi, 32'h12345678);
      chk("flush_lo", lo, 32'h9ABCDEF0);

      // directed table; consecutive ops also exercise acceptance in the done cycle
      @(negedge clk);
      foreach (vecs[i]) begin
         run_op(vecs[i].f, vecs[i].a, vecs[i].b, rh, rl, lat, nst);
         chk({vecs[i].name, "_hi"}, rh, vecs[i].ehi);
         chk({vecs[i].name, "_lo"}, rl, vecs[i].elo);
         chk({vecs[i].name, "_lat"}, lat, (FAST && is_mul(vecs[i].f)) ? 1 : 34);
         chk({vecs[i].name, "_stall"}, nst, (FAST && is_mul(vecs[i].f)) ? 0 : 34);
      end

      for (int n = 0; n < 40; n++) begin
         logic [31:0] a, b;
         case ($urandom_range(0, 3))
            0: f = F_MULT;
            1: f = F_MULTU;
            2: f = F_DIV;
            default: f = F_DIVU;
         endcase
         a = $urandom;
         if ($urandom_range(0, 7) == 0) b = 32'd0;
         else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 15);
         else b = $urandom;
         if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
         model(f, a, b, eh, el);
         run_op(f, a, b, rh, rl, lat, nst);
         chk($sformatf("rnd%0d_f%0h_hi", n, f), rh, eh);
         chk($sformatf("rnd%0d_f%0h_lo", n, f), rl, el);
         chk($sformatf("rnd%0d_lat", n), lat, (FAST && is_mul(f)) ? 1 : 34);
      end

      // asynchronous reset in the middle of an iterative operation
      run_op(F_MULTU, 32'hFFFFFFFF, 32'h2, rh, rl, lat, nst);
      @(negedge clk);
      start = 1'b1; funct = FAST ? F_DIVU : F_MULTU; operand_1 = 32'h1234; operand_2 = 32'h56;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_hi", hi, 0);
      chk("midrst_lo", lo, 0);
      chk("midrst_done", done, 0);
      chk("midrst_stall", stall_req, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(F_DIVU, 32'd100, 32'd7, rh, rl, lat, nst);
      chk("post_rst_hi", rh, 32'd2);
      chk("post_rst_lo", rl, 32'd14);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
